// File: rtl/tff_updown_counter.sv
// Parametrised up/down counter built as a toggle-flip-flop chain, with clamped parallel load,
// programmable terminal value and wrap/saturate handling at the range ends.
module tff_updown_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] toggle;
    logic             wrap_q, wrap_d;
    logic             at_top, at_bottom;
    logic             run;

    assign at_top    = (count_q == MaxVal);
    assign at_bottom = (count_q == '0);

    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        toggle = '0;
        run    = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            toggle[i] = run;
            run       = run & (up_dn ? count_q[i] : ~count_q[i]);
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (d > MaxVal) ? MaxVal : d;
        end else if (enable) begin
            if (up_dn && at_top) begin
                if (!sat_mode) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else if (!up_dn && at_bottom) begin
                if (!sat_mode) begin
                    count_d = MaxVal;
                    wrap_d  = 1'b1;
                end
            end else begin
                count_d = count_q ^ toggle;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q    = count_q;
    assign wrap = wrap_q;
    assign tc   = up_dn ? at_top : at_bottom;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Self-checking bench: three counter configurations (1-bit T flip-flop, 4-bit full range,
// 4-bit mod-10) driven by shared stimulus and compared against an arithmetic model.
module tb_tff_updown_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable, up_dn, load, sat_mode;
    logic [3:0] d;
    logic [0:0] q_a;
    logic [3:0] q_b, q_c;
    logic       tc_a, tc_b, tc_c;
    logic       wrap_a, wrap_b, wrap_c;

    int checks   = 0;
    int failures = 0;
    int exp_q[3];
    int exp_w[3];
    int max_c[3] = '{1, 15, 9};

    always #5 clk = ~clk;

    tff_updown_counter #(.WIDTH(1), .MAX_COUNT(1)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .d(d[0:0]), .sat_mode(sat_mode), .q(q_a), .tc(tc_a), .wrap(wrap_a)
    );

    tff_updown_counter #(.WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .d(d), .sat_mode(sat_mode), .q(q_b), .tc(tc_b), .wrap(wrap_b)
    );

    tff_updown_counter #(.WIDTH(4), .MAX_COUNT(9)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .d(d), .sat_mode(sat_mode), .q(q_c), .tc(tc_c), .wrap(wrap_c)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int exp_tc(input int i);
        return up_dn ? int'(exp_q[i] == max_c[i]) : int'(exp_q[i] == 0);
    endfunction

    task automatic check_tc(input string tag);
        check({tag, "_tc_a"}, 16'(tc_a), 16'(exp_tc(0)));
        check({tag, "_tc_b"}, 16'(tc_b), 16'(exp_tc(1)));
        check({tag, "_tc_c"}, 16'(tc_c), 16'(exp_tc(2)));
    endtask

    task automatic check_all(input string tag);
        check({tag, "_q_a"}, 16'(q_a), 16'(exp_q[0]));
        check({tag, "_q_b"}, 16'(q_b), 16'(exp_q[1]));
        check({tag, "_q_c"}, 16'(q_c), 16'(exp_q[2]));
        check({tag, "_wrap_a"}, 16'(wrap_a), 16'(exp_w[0]));
        check({tag, "_wrap_b"}, 16'(wrap_b), 16'(exp_w[1]));
        check({tag, "_wrap_c"}, 16'(wrap_c), 16'(exp_w[2]));
        check_tc(tag);
    endtask

    // Reference: range 0..max, clamp on load, wrap or hold at the ends.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int dv;
            dv = (i == 0) ? int'(d[0]) : int'(d);
            exp_w[i] = 0;
            if (load) begin
                exp_q[i] = (dv > max_c[i]) ? max_c[i] : dv;
            end else if (enable) begin
                if (up_dn) begin
                    if (exp_q[i] < max_c[i]) exp_q[i] = exp_q[i] + 1;
                    else if (!sat_mode) begin
                        exp_q[i] = 0;
                        exp_w[i] = 1;
                    end
                end else begin
                    if (exp_q[i] > 0) exp_q[i] = exp_q[i] - 1;
                    else if (!sat_mode) begin
                        exp_q[i] = max_c[i];
                        exp_w[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic step(input string tag, input logic en, input logic up, input logic ld,
                        input logic [3:0] dv, input logic sat);
        @(negedge clk);
        enable   = en;
        up_dn    = up;
        load     = ld;
        d        = dv;
        sat_mode = sat;
        #1;
        check_tc({tag, "_pre"});
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset with undriven control inputs; the count must not pick up the X.
        reset    = 1'b1;
        enable   = 1'bx;
        up_dn    = 1'bx;
        load     = 1'bx;
        d        = 'x;
        sat_mode = 1'bx;
        repeat (2) @(posedge clk);
        #1;
        up_dn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q[i] = 0;
            exp_w[i] = 0;
        end
        #1;
        check_all("reset_hold");

        @(negedge clk);
        enable   = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        d        = '0;
        sat_mode = 1'b0;
        reset    = 1'b0;

        // Count up 17 clocks: 4-bit wraps 15->0, mod-10 wraps 9->0, 1-bit toggles.
        for (int k = 0; k < 17; k++) step("up17", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        repeat (2) step("freeze", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Load 3 then count down through 0 to the terminal value.
        step("load3", 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
        repeat (5) step("down5", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // Clamped load, then saturation at both ends.
        step("load12", 1'b0, 1'b1, 1'b1, 4'd12, 1'b0);
        repeat (3) step("sat_up", 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        step("load0", 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
        repeat (2) step("sat_dn", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);

        // Load beats enable on the same edge.
        step("load_en", 1'b1, 1'b1, 1'b1, 4'd5, 1'b0);

        // Short asynchronous reset pulse mid-cycle aborts the count.
        step("load7", 1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_q[i] = 0;
            exp_w[i] = 0;
        end
        check_all("async_rst");

        // Direction flips every third clock.
        for (int k = 0; k < 15; k++) step("dir_flip", 1'b1, ((k / 3) % 2) == 0, 1'b0, 4'd0, 1'b0);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step("rand", ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 15) == 0),
                 4'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
